// File: rtl/wb_mem_pkg.sv
// rtl/wb_mem_pkg.sv - shared types and constants for wb_wait_mem (timer via WB_MEM_TIMER_EN)
package wb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_mem_state_t;

  // Address bit that steers a request to the timer registers when the timer is built in.
  localparam int TIMER_SEL_BIT = 29;

  // Timer register word offsets (adr[0]).
  localparam logic TMR_COUNT  = 1'b0;
  localparam logic TMR_STATUS = 1'b1;

endpackage

// File: rtl/wb_mem_timer.sv
// rtl/wb_mem_timer.sv - count-down timer with sticky pending flag, used under WB_MEM_TIMER_EN
module wb_mem_timer
  import wb_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        off,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        cnt_wr;
  logic        st_wr;
  logic        expire;

  assign cnt_wr = wr_en && (off == TMR_COUNT);
  assign st_wr  = wr_en && (off == TMR_STATUS);

  // Counter load/decrement; expiry beats a concurrent STATUS clear.
  always_comb begin
    count_d   = count_q;
    pending_d = pending_q;
    expire    = 1'b0;
    if (cnt_wr) begin
      count_d = wr_data;
    end else if (count_q != 32'd0) begin
      count_d = count_q - 32'd1;
      expire  = (count_q == 32'd1);
    end
    if (expire) begin
      pending_d = 1'b1;
    end else if (st_wr) begin
      pending_d = 1'b0;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign rd_data = (off == TMR_STATUS) ? {31'b0, pending_q} : count_q;
  assign irq     = pending_q;

endmodule

// File: rtl/wb_wait_mem.sv
// rtl/wb_wait_mem.sv - Wishbone classic memory with bounded wait states; timer via WB_MEM_TIMER_EN
module wb_wait_mem
  import wb_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_MAX   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] bus__adr,
  input  logic        bus__cyc,
  input  logic        bus__stb,
  input  logic        bus__we,
  input  logic [3:0]  bus__sel,
  input  logic [31:0] bus__dat_w,
  output logic [31:0] bus__dat_r,
  output logic        bus__ack,
  input  logic [1:0]  wait_cycles,
  output logic        irq
);

  localparam int         DEPTH      = 1 << DEPTH_LOG2;
  // wait_cycles is only 2 bits wide, so any WAIT_MAX of 3 or more never clamps.
  localparam logic [1:0] WAIT_CLAMP = (WAIT_MAX >= 3) ? 2'd3 : 2'(WAIT_MAX);

  wb_mem_state_t state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [29:0]   adr_q, adr_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   dat_q, dat_d;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [31:0]           mem_rdata;
  logic [31:0]           tmr_rdata;
  logic [1:0]            wait_load;
  logic                  tmr_sel;
  logic                  commit;
  logic                  mem_wr;
  logic                  unused_adr;

  assign wait_load  = (wait_cycles > WAIT_CLAMP) ? WAIT_CLAMP : wait_cycles;
  assign mem_idx    = adr_q[DEPTH_LOG2-1:0];
  // Upper address bits alias onto the same words.
  assign unused_adr = ^adr_q[29:DEPTH_LOG2];

`ifdef WB_MEM_TIMER_EN
  assign tmr_sel = adr_q[TIMER_SEL_BIT];
`else
  assign tmr_sel = 1'b0;
`endif

  // Writes land on the edge that ends the ACK cycle; reset in ACK drops them.
  assign commit = (state_q == ACK) && we_q && !rst;
  assign mem_wr = commit && !tmr_sel;

  // Request FSM: accept and latch in IDLE, count wait states, abort on cyc drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (bus__cyc && bus__stb) begin
          adr_d   = bus__adr;
          we_d    = bus__we;
          sel_d   = bus__sel;
          dat_d   = bus__dat_w;
          cnt_d   = wait_load;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!bus__cyc) begin
          state_d = IDLE;
        end else if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and request latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      adr_q   <= 30'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
    end
  end

  // Byte-lane RAM write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) begin
          mem[mem_idx][8*b +: 8] <= dat_q[8*b +: 8];
        end
      end
    end
  end

  assign mem_rdata = mem[mem_idx];

`ifdef WB_MEM_TIMER_EN
  wb_mem_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (commit && tmr_sel),
    .off     (adr_q[0]),
    .wr_data (dat_q),
    .rd_data (tmr_rdata),
    .irq     (irq)
  );
`else
  assign tmr_rdata = 32'd0;
  assign irq       = 1'b0;
`endif

  assign bus__ack = (state_q == ACK);

  // Read mux: data only on a read ack, zero otherwise.
  always_comb begin
    bus__dat_r = 32'd0;
    if (bus__ack && !we_q) begin
      bus__dat_r = tmr_sel ? tmr_rdata : mem_rdata;
    end
  end

endmodule
